// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA framebuffer arbiter slice.
// Timing is 640x480@60 with a 4x-replicated 160x120 framebuffer.
package vga_pkg;
  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int H_TOTAL    = 800;
  localparam int V_TOTAL    = 525;
  localparam int SCALE_LOG2 = 2;
  localparam int FB_W       = H_ACTIVE >> SCALE_LOG2;
  localparam int FB_H       = V_ACTIVE >> SCALE_LOG2;
  localparam int FB_PIX     = FB_W * FB_H;
  localparam int DATA_W     = 8;
  localparam int OFS_W      = 15;
  localparam int COL_W      = 10;
  localparam int ROW_W      = 9;

  typedef enum logic {STABLE, PENDING} swap_state_t;
endpackage

// File: rtl/fb_addr_gen.sv
// Screen column/row -> framebuffer pixel offset: (row>>2)*160 + (column>>2).
// The *160 is done as (r<<7)+(r<<5) so no multiplier is inferred.
module fb_addr_gen
  import vga_pkg::*;
(
  input  logic [COL_W-1:0] column,
  input  logic [ROW_W-1:0] row,
  output logic [OFS_W-1:0] offset
);
  logic [OFS_W-1:0] r;
  logic [OFS_W-1:0] c;

  assign r      = OFS_W'(row >> SCALE_LOG2);
  assign c      = OFS_W'(column >> SCALE_LOG2);
  assign offset = (r << 7) + (r << 5) + c;
endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scan-out reads own every 4th active cycle,
// host writes take the rest; front/back banks swap only at vblank start.
module vga_fb_arbiter
  import vga_pkg::*;
(
  input  logic              pxclk,
  input  logic              rst_n,
  input  logic [COL_W-1:0]  column,
  input  logic [ROW_W-1:0]  row,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [OFS_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_drop,
  input  logic              swap_req,
  output logic              swap_pending,
  output logic              swap_done,
  output logic              front_bank,
  output logic              mem_en,
  output logic              mem_we,
  output logic [OFS_W:0]    mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid
);
  logic             active, scan_slot, in_range, wr_fire, vblank_start;
  logic [OFS_W-1:0] scan_off;
  logic [2:1]       vld_pipe;
  logic             slot_d1;
  logic             toggle;
  swap_state_t      state, state_n;

  fb_addr_gen u_addr (
    .column (column),
    .row    (row),
    .offset (scan_off)
  );

  assign active       = (column < COL_W'(H_ACTIVE)) && (row < ROW_W'(V_ACTIVE));
  assign scan_slot    = active && (column[1:0] == 2'd0);
  assign wr_ready     = ~scan_slot;
  assign in_range     = wr_addr < OFS_W'(FB_PIX);
  assign wr_fire      = wr_valid && wr_ready && in_range;
  assign vblank_start = (column == '0) && (row == ROW_W'(V_ACTIVE));
  assign swap_pending = (state == PENDING);
  assign pix_valid    = vld_pipe[2];
  assign mem_wdata    = wr_data;

  // Writes target the back bank as seen before any swap landing this cycle.
  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = {front_bank, scan_off};
    if (rst_n) begin
      if (scan_slot) begin
        mem_en = 1'b1;
      end else if (wr_fire) begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {~front_bank, wr_addr};
      end
    end
  end

  always_comb begin
    state_n = state;
    toggle  = 1'b0;
    case (state)
      STABLE:
        if (swap_req) begin
          if (vblank_start) toggle  = 1'b1;
          else              state_n = PENDING;
        end
      PENDING:
        if (vblank_start) begin
          toggle  = 1'b1;
          state_n = STABLE;
        end
      default: state_n = STABLE;
    endcase
  end

  always_ff @(posedge pxclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= STABLE;
      front_bank <= 1'b0;
      swap_done  <= 1'b0;
      wr_drop    <= 1'b0;
    end else begin
      state      <= state_n;
      front_bank <= front_bank ^ toggle;
      swap_done  <= toggle;
      wr_drop    <= wr_valid && wr_ready && !in_range;
    end
  end

  // Read data lands one cycle after the slot; register it the cycle after.
  always_ff @(posedge pxclk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      slot_d1  <= 1'b0;
      pix_data <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], active};
      slot_d1  <= scan_slot;
      if (!vld_pipe[1])  pix_data <= '0;
      else if (slot_d1)  pix_data <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: a RAM model answers the DUT, a shadow
// copy plus bank/FSM model predicts every output.
module tb_vga_fb_arbiter;
  import vga_pkg::*;

  logic              pxclk = 1'b0;
  logic              rst_n = 1'b0;
  logic [9:0]        column = '0;
  logic [8:0]        row = '0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [14:0]       wr_addr = '0;
  logic [7:0]        wr_data = '0;
  logic              wr_drop;
  logic              swap_req = 1'b0;
  logic              swap_pending, swap_done, front_bank;
  logic              mem_en, mem_we;
  logic [15:0]       mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata = '0;
  logic [7:0]        pix_data;
  logic              pix_valid;

  vga_fb_arbiter dut (
    .pxclk(pxclk), .rst_n(rst_n), .column(column), .row(row),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_drop(wr_drop), .swap_req(swap_req), .swap_pending(swap_pending),
    .swap_done(swap_done), .front_bank(front_bank), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pix_data(pix_data), .pix_valid(pix_valid)
  );

  always #5 pxclk = ~pxclk;

  logic [7:0] ram    [0:65535];
  logic [7:0] shadow [0:65535];

  always @(posedge pxclk)
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end

  typedef struct {logic v; logic [7:0] d;} pix_t;
  pix_t       q[$];
  logic [7:0] m_pix;
  logic       m_fb, m_pend, m_done, m_drop;
  int         n_chk = 0;
  int         n_pass = 0;

  function automatic logic [7:0] pat(input int a);
    return 8'((a * 37 + 11) ^ (a >> 8));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_pix = '0; m_fb = 1'b0; m_pend = 1'b0; m_done = 1'b0; m_drop = 1'b0;
  endtask

  // Entered and left at posedge+1.
  task automatic cyc(input int c, input int r, input logic wv, input int wa,
                     input logic [7:0] wd, input logic sr);
    logic act, slot, vb, rdy, fire, drp;
    logic [15:0] radr;
    pix_t e;
    chk("front_bank", front_bank, m_fb);
    chk("swap_pending", swap_pending, m_pend);
    chk("swap_done", swap_done, m_done);
    chk("wr_drop", wr_drop, m_drop);
    if (q.size() == 2) begin
      e = q.pop_front();
      chk("pix_valid", pix_valid, e.v);
      chk("pix_data", pix_data, e.d);
    end
    column = 10'(c); row = 9'(r);
    wr_valid = wv; wr_addr = 15'(wa); wr_data = wd; swap_req = sr;
    #1;
    act  = (c < 640) && (r < 480);
    slot = act && (c % 4 == 0);
    radr = {m_fb, 15'((r / 4) * 160 + c / 4)};
    rdy  = !slot;
    fire = wv && rdy && (wa < 19200);
    drp  = wv && rdy && (wa >= 19200);
    chk("wr_ready", wr_ready, rdy);
    chk("mem_en", mem_en, slot || fire);
    chk("mem_we", mem_we, fire);
    if (slot) chk("rd_addr", mem_addr, radr);
    if (!act)      m_pix = '0;
    else if (slot) m_pix = shadow[radr];
    q.push_back('{act, m_pix});
    if (fire) begin
      chk("wr_maddr", mem_addr, {~m_fb, 15'(wa)});
      chk("wr_wdata", mem_wdata, wd);
      shadow[{~m_fb, 15'(wa)}] = wd;
    end
    vb = (c == 0) && (r == 480);
    m_drop = drp;
    m_done = 1'b0;
    if ((m_pend || sr) && vb) begin
      m_fb = ~m_fb; m_pend = 1'b0; m_done = 1'b1;
    end else if (sr) m_pend = 1'b1;
    @(posedge pxclk); #1;
  endtask

  // Asserts reset mid-cycle and checks the outputs before any clock edge.
  task automatic do_reset();
    #3;
    rst_n = 1'b0; column = '0; row = '0; wr_valid = 1'b0; swap_req = 1'b0;
    #1;
    chk("rst_pix_data", pix_data, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_swap_pending", swap_pending, 0);
    chk("rst_swap_done", swap_done, 0);
    chk("rst_front_bank", front_bank, 0);
    chk("rst_wr_drop", wr_drop, 0);
    chk("rst_mem_en", mem_en, 0);
    model_reset();
    repeat (2) @(posedge pxclk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int wa;
    for (int i = 0; i < 65536; i++) begin
      ram[i] = pat(i); shadow[i] = pat(i);
    end
    ram[16'h00A2] = 8'hA5; shadow[16'h00A2] = 8'hA5;
    model_reset();
    @(posedge pxclk); #1;
    do_reset();

    // first fetch at (0,0), then part of row 0
    for (int c = 0; c < 16; c++) cyc(c, 0, 0, 0, 0, 0);
    // row 5 column 8 -> offset 0xA2 returns 0xA5
    for (int c = 4; c < 16; c++) cyc(c, 5, 0, 0, 0, 0);
    // continuous host writes across active video
    wa = 16;
    for (int c = 0; c < 32; c++) begin
      cyc(c, 10, 1, wa, pat(wa + 99), 0);
      if (c % 4 != 0) wa++;
    end
    // blanking: out-of-range and edge addresses
    cyc(700, 490, 1, 19200, 8'h11, 0);
    cyc(701, 490, 1, 19199, 8'h22, 0);
    cyc(702, 490, 1, 32767, 8'h33, 0);
    cyc(703, 490, 0, 0, 0, 0);
    cyc(800, 525, 1, 7, 8'h44, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // swap request, a second one absorbed, one toggle at vblank
    cyc(0, 100, 0, 0, 0, 1);
    for (int c = 1; c < 6; c++) cyc(c, 100, 0, 0, 0, 0);
    cyc(4, 200, 0, 0, 0, 1);
    cyc(5, 200, 0, 0, 0, 0);
    cyc(636, 479, 0, 0, 0, 0);
    cyc(639, 479, 0, 0, 0, 0);
    cyc(799, 479, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) cyc(c, 480, 0, 0, 0, 0);
    // displaying bank 1 now: shows the earlier host writes
    for (int c = 60; c < 100; c++) cyc(c, 0, 0, 0, 0, 0);
    // swap_req coincident with vblank_start plus a write, twice
    for (int k = 0; k < 2; k++) begin
      cyc(799, 479, 0, 0, 0, 0);
      cyc(0, 480, 1, 5 + k, 8'h5A + 8'(k), 1);
      cyc(1, 480, 0, 0, 0, 0);
      cyc(2, 480, 0, 0, 0, 0);
    end
    // mid-frame reset while front_bank=1 and pixels visible
    for (int c = 0; c < 12; c++) cyc(c, 50, 0, 0, 0, 0);
    do_reset();
    for (int c = 0; c < 12; c++) cyc(c, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) cyc(640 + c, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
